// File: rtl/water_supply_controller_if.sv
// Sensor, command and drive signals of the water supply controller.
// The slave side is the controller; the master side is the plant or bench.
interface water_supply_controller_if;
    logic       low;
    logic       mid;
    logic       high;
    logic       demand;
    logic       fault_clear;
    logic       pump_on;
    logic       valve_open;
    logic       error;
    logic [1:0] state;
    logic [1:0] level;

    modport master (
        output low, mid, high, demand, fault_clear,
        input  pump_on, valve_open, error, state, level
    );

    modport slave (
        input  low, mid, high, demand, fault_clear,
        output pump_on, valve_open, error, state, level
    );
endinterface

// File: rtl/water_supply_controller.sv
// Tank fill sequencer: syncs/debounces level sensors, rejects inconsistent levels, drives pump and valve.
// Optional fill timeout (dry-run / failed-pump protection) is built when WATER_FILL_TIMEOUT_EN is defined.
module water_supply_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MIN_OFF_CYCLES  = 8,
    parameter int FILL_TIMEOUT    = 1000
) (
    input logic                      clock,
    input logic                      reset,
    water_supply_controller_if.slave wsc
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_FAULT = 2'd3
    } state_e;

    localparam int            DW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DMAX  = DW'(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DLOAD = DW'(DEBOUNCE_CYCLES - 1);
    localparam int            TW    = $clog2(MIN_OFF_CYCLES + 1);
    localparam logic [TW-1:0] TMAX  = TW'(MIN_OFF_CYCLES);
    localparam logic [TW-1:0] TEXP  = TW'(MIN_OFF_CYCLES - 1);

    logic [2:0]    sync1_q, sync2_q, filt_q, filt_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [TW-1:0] off_q, off_d;
    logic [1:0]    level_q, level_d;
    state_e        state_q, state_d;
    logic          pump_q, valve_q, err_q, valve_d;
    logic          stable, valid, off_exp, timeout;

    // sync2_q takes sync1_q next edge, so equality means the synchronised vector holds.
    assign stable  = (sync1_q == sync2_q);
    // The cycle in progress counts as off time, so a restart lands MIN_OFF_CYCLES after the fall.
    assign off_exp = (off_q >= TEXP);

    always_comb begin
        dcnt_d = dcnt_q;
        filt_d = filt_q;
        if (!stable) begin
            dcnt_d = '0;
        end else begin
            if (dcnt_q != DMAX) dcnt_d = dcnt_q + 1'b1;
            if (dcnt_q >= DLOAD) filt_d = sync2_q;
        end
        level_d = {1'b0, filt_d[0]} + {1'b0, filt_d[1]} + {1'b0, filt_d[2]};
    end

    always_comb begin
        valid = 1'b0;
        case (filt_q)
            3'b000, 3'b001, 3'b011, 3'b111: valid = 1'b1;
            default:                        valid = 1'b0;
        endcase
    end

`ifdef WATER_FILL_TIMEOUT_EN
    localparam int            FW   = $clog2(FILL_TIMEOUT + 1);
    localparam logic [FW-1:0] FMAX = FW'(FILL_TIMEOUT);

    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [1:0]    lvl_last_q;

    always_comb begin
        fcnt_d = fcnt_q;
        if (state_q != S_FILL || level_q > lvl_last_q) fcnt_d = '0;
        else if (fcnt_q != FMAX)                        fcnt_d = fcnt_q + 1'b1;
    end

    assign timeout = (state_q == S_FILL) && (fcnt_q == FMAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fcnt_q     <= '0;
            lvl_last_q <= 2'd0;
        end else begin
            fcnt_q     <= fcnt_d;
            lvl_last_q <= level_q;
        end
    end
`else
    // Never true for a legal timeout; keeps the parameter referenced in this build.
    assign timeout = (FILL_TIMEOUT < 0);
`endif

    always_comb begin
        state_d = state_q;
        if (!valid || timeout) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_IDLE:  if (level_q <= 2'd1 && off_exp) state_d = S_FILL;
                S_FILL:  if (level_q == 2'd3)            state_d = S_IDLE;
                S_FAULT: if (wsc.fault_clear)           state_d = S_IDLE;
                default:                                 state_d = S_FAULT;
            endcase
        end
        off_d = off_q;
        if (state_q == S_FILL && state_d != S_FILL) off_d = '0;
        else if (off_q != TMAX)                     off_d = off_q + 1'b1;
        valve_d = wsc.demand && (level_q != 2'd0) && (state_d != S_FAULT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            filt_q  <= 3'b000;
            dcnt_q  <= '0;
            level_q <= 2'd0;
            off_q   <= TMAX;
            state_q <= S_IDLE;
            pump_q  <= 1'b0;
            valve_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= {wsc.high, wsc.mid, wsc.low};
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            dcnt_q  <= dcnt_d;
            level_q <= level_d;
            off_q   <= off_d;
            state_q <= state_d;
            pump_q  <= (state_d == S_FILL);
            valve_q <= valve_d;
            err_q   <= (state_d == S_FAULT);
        end
    end

    assign wsc.pump_on    = pump_q;
    assign wsc.valve_open = valve_q;
    assign wsc.error      = err_q;
    assign wsc.state      = state_q;
    assign wsc.level      = level_q;
endmodule

// File: tb/tb_water_supply_controller.sv
// Randomised bench for water_supply_controller against a cycle-level behavioural model.
// The model describes filtering as "a value seen on D+1 consecutive edges" and the off time by edge numbers.
module tb_water_supply_controller;
    localparam int D  = 4;
    localparam int MO = 8;
    localparam int FT = 50;

    logic clock = 1'b0;
    logic reset;
    water_supply_controller_if wsc ();

    water_supply_controller #(
        .DEBOUNCE_CYCLES(D),
        .MIN_OFF_CYCLES (MO),
        .FILL_TIMEOUT   (FT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .wsc  (wsc)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // behavioural model
    logic [2:0] hist[$];
    logic [2:0] m_filt;
    int m_state, m_pump, m_valve, m_err, m_lvl;
    int edge_n, fall_edge, fc, prevlvl;

    function automatic int popc(input logic [2:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]);
    endfunction

    function automatic bit ok_vec(input logic [2:0] v);
        return (v == 3'b000) || (v == 3'b001) || (v == 3'b011) || (v == 3'b111);
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i <= D; i++) hist.push_back(3'b000);
        m_filt = 3'b000;
        m_state = 0; m_pump = 0; m_valve = 0; m_err = 0; m_lvl = 0;
        edge_n = 0; fall_edge = -100000; fc = 0; prevlvl = 0;
    endtask

    task automatic model_step(input logic [2:0] raw, input bit dem, input bit fclr);
        int lvl, nxt;
        bit same, tmo;
        logic [2:0] nf;
        edge_n++;
        lvl  = popc(m_filt);
        nf   = m_filt;
        same = 1'b1;
        for (int i = 0; i <= D; i++)
            if (hist[hist.size()-1-i] != hist[hist.size()-1]) same = 1'b0;
        if (same) nf = hist[hist.size()-1];
        hist.push_back(raw);
        if (hist.size() > D + 1) void'(hist.pop_front());
`ifdef WATER_FILL_TIMEOUT_EN
        tmo = (m_state == 1) && (fc >= FT);
`else
        tmo = 1'b0;
`endif
        if (!ok_vec(m_filt) || tmo) nxt = 3;
        else if (m_state == 0) nxt = (lvl <= 1 && edge_n - fall_edge >= MO) ? 1 : 0;
        else if (m_state == 1) nxt = (lvl == 3) ? 0 : 1;
        else nxt = fclr ? 0 : 3;
        if (m_state != 1 || lvl > prevlvl) fc = 0;
        else if (fc < FT) fc++;
        prevlvl = lvl;
        if (m_state == 1 && nxt != 1) fall_edge = edge_n;
        m_valve = (dem && lvl >= 1 && nxt != 3) ? 1 : 0;
        m_pump  = (nxt == 1) ? 1 : 0;
        m_err   = (nxt == 3) ? 1 : 0;
        m_state = nxt;
        m_filt  = nf;
        m_lvl   = popc(nf);
    endtask

    // Called at a falling edge: check, drive, advance model, move to next falling edge.
    task automatic cycle(input logic [2:0] raw, input bit dem, input bit fclr);
        chk("pump_on",    wsc.pump_on,    m_pump);
        chk("valve_open", wsc.valve_open, m_valve);
        chk("error",      wsc.error,      m_err);
        chk("state",      wsc.state,      m_state);
        chk("level",      wsc.level,      m_lvl);
        {wsc.high, wsc.mid, wsc.low} = raw;
        wsc.demand      = dem;
        wsc.fault_clear = fclr;
        model_step(raw, dem, fclr);
        @(posedge clock);
        @(negedge clock);
    endtask

    // dem/fclr: 0 or 1 = fixed, 2 = random each cycle
    task automatic run_seg(input logic [2:0] v, input int hold, input int dem, input int fclr);
        bit d, f;
        for (int i = 0; i < hold; i++) begin
            d = (dem == 2) ? ($urandom_range(0, 3) != 0) : (dem != 0);
            f = (fclr == 2) ? ($urandom_range(0, 3) == 0) : (fclr != 0);
            cycle(v, d, f);
        end
    endtask

    task automatic async_reset_check();
        #2;
        {wsc.high, wsc.mid, wsc.low} = 3'b000;
        wsc.fault_clear = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_pump_on", wsc.pump_on,    0);
        chk("rst_valve",   wsc.valve_open, 0);
        chk("rst_error",   wsc.error,      0);
        chk("rst_state",   wsc.state,      0);
        chk("rst_level",   wsc.level,      0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    logic [2:0] good_tbl[4];
    logic [2:0] bad_tbl[4];

    initial begin
        logic [2:0] v;
        int guard;
        good_tbl = '{3'b000, 3'b001, 3'b011, 3'b111};
        bad_tbl  = '{3'b010, 3'b100, 3'b101, 3'b110};
        reset = 1'b1;
        {wsc.high, wsc.mid, wsc.low} = 3'b000;
        wsc.demand = 1'b1;
        wsc.fault_clear = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();

        // fill from empty, level steps, short-cycle lockout
        run_seg(3'b000, 70, 1, 0);
        run_seg(3'b000, 5,  1, 1);
        run_seg(3'b001, 20, 1, 0);
        run_seg(3'b011, 20, 1, 0);
        run_seg(3'b111, 7,  1, 0);
        run_seg(3'b001, 30, 1, 0);
        // glitch on high while at mid
        run_seg(3'b011, 20, 2, 0);
        run_seg(3'b111, 2,  1, 0);
        run_seg(3'b011, 20, 1, 0);
        // inconsistent sensors, clear refused until restored
        run_seg(3'b101, 10, 1, 0);
        run_seg(3'b101, 5,  1, 1);
        run_seg(3'b011, 10, 1, 0);
        run_seg(3'b011, 5,  1, 1);
        run_seg(3'b011, 20, 0, 0);
        run_seg(3'b000, 15, 1, 0);

        for (int s = 0; s < 160; s++) begin
            v = ($urandom_range(0, 99) < 85) ? good_tbl[$urandom_range(0, 3)]
                                             : bad_tbl[$urandom_range(0, 3)];
            run_seg(v, $urandom_range(1, 25), 2, 2);
            if (s == 80) begin
                run_seg(3'b000, 10, 1, 1);
                guard = 0;
                while (m_state != 1 && guard < 60) begin
                    cycle(3'b000, 1'b1, 1'b1);
                    guard++;
                end
                chk("reach_fill", m_state, 1);
                async_reset_check();
                run_seg(3'b000, 10, 1, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/water_supply_controller.md
Name: water_supply_controller

Overview:
Sequences the tank-filling pump and the consumer outlet valve of the water supply from the three tank level sensors (low, mid, high).
- Synchronises and debounces the sensors.
- Rejects inconsistent sensor combinations: a higher level set without all lower levels is a fault.
- Runs a fill/idle/fault state machine with anti-short-cycle protection for the pump.
- Sits between the raw sensor inputs and the pump/valve drivers; its error output feeds the alarm.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised sensor vector must hold before it is accepted (>=1)
MIN_OFF_CYCLES, 8, minimum cycles the pump stays off before it may restart (>=1)
FILL_TIMEOUT, 1000, max cycles in FILL without a level increase (used only with the optional feature)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
low  input  1  raw low-level sensor, asynchronous
mid  input  1  raw mid-level sensor, asynchronous
high  input  1  raw high-level sensor, asynchronous
demand  input  1  consumer requests water, synchronous
fault_clear  input  1  operator acknowledge, synchronous, level-sensitive
pump_on  output  1  pump drive
valve_open  output  1  outlet valve drive
error  output  1  1 while in FAULT
state  output  2  0=IDLE, 1=FILL, 3=FAULT (2 unused, never driven)
level  output  2  filtered level: 0 empty, 1 low, 2 mid, 3 high

Behaviour:
- Reset values: all outputs 0; sync flops 000; filtered vector 000; debounce counter 0; off-timer saturated (expired); state IDLE.
- Sync: {high,mid,low} passes through a 2-flop synchroniser.
- Debounce: counter clears whenever the synchronised vector differs from the previous cycle. The filtered vector loads after DEBOUNCE_CYCLES consecutive equal samples. Raw change to filtered change = 2+DEBOUNCE_CYCLES cycles.
- Valid filtered {high,mid,low}: 000, 001, 011, 111. level = count of set bits. Any other pattern is invalid.
- All outputs are registered. pump_on, valve_open and state change 1 cycle after the filtered vector changes.
- FSM:
  - IDLE: pump off. Go to FILL when level<=1 and the off-timer has expired.
  - FILL: pump on. Go to IDLE when level==3.
  - FAULT: pump off, valve closed, error=1. Go to IDLE when fault_clear=1 and the filtered vector is valid. Otherwise stay in FAULT, even if fault_clear is held.
  - From any state: an invalid filtered vector forces FAULT on the next edge.
- Priority: FAULT entry > FILL/IDLE transitions. In FILL, invalid vector together with level==3 gives FAULT.
- Off-timer: loads 0 when pump_on falls (FILL to IDLE or FILL to FAULT), increments to saturation, expires at MIN_OFF_CYCLES. The width holds MIN_OFF_CYCLES without wrap.
- valve_open = demand & (level>=1) & state!=FAULT, registered. The valve closes 1 cycle after level reaches 0, independent of the pump.
- Reset asserted mid-FILL: pump_on drops asynchronously and all state returns to reset values.

Optional Feature:
Macro: WATER_FILL_TIMEOUT_EN
- Defined: a fill counter clears on FILL entry and on every cycle where level increases, and increments otherwise while in FILL. When it reaches FILL_TIMEOUT, the next edge enters FAULT (dry-run or failed-pump protection). The counter is held at 0 outside FILL.
- Undefined: no counter is instantiated and FILL exits only via level==3 or an invalid vector.

Test Plan:
1. Reset release with sensors 000, D=4 → level=0; pump_on=1, state=1 at cycle 1 after reset (timer pre-expired, filtered already 000); valve_open=0 even with demand=1.
2. Filling: raise low, mid, high in order, each held 20 cycles → level steps 1, 2, 3, each 6 cycles after the raw edge; pump_on=0 and state=0 at 7 cycles after the raw high edge.
3. Short-cycle: from full, drop to 001 right after the pump stops (MIN_OFF_CYCLES=8) → pump stays off until 8 cycles after the fall, then pump_on=1.
4. Glitch: pulse high=1 for 2 cycles while at 011 → level stays 2; no FAULT.
5. Inconsistent sensors 101 held 10 cycles → error=1, state=3, pump_on=0, valve_open=0. fault_clear with 101 still present → stays in FAULT. Restore 011, then fault_clear → IDLE.
6. With WATER_FILL_TIMEOUT_EN and FILL_TIMEOUT=50: enter FILL at 000 and hold → FAULT at cycle 51 after FILL entry. Without the macro, the same stimulus stays in FILL indefinitely.
